// File: rtl/audio_pkg.sv
// Shared definitions for the sound-out sample path: playback states,
// sample word width and default buffer geometry.
package audio_pkg;

   // Playback sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // One stereo sample word: {L[15:0], R[15:0]}
   localparam int SAMPLE_W  = 32;

   // Default buffer geometry
   localparam int DEF_DEPTH = 16;
   localparam int DEF_BURST = 4;

endpackage : audio_pkg

// File: rtl/audio_out_fifo_if.sv
// Bus-side and serializer-side signals of the sound-out buffer.
// master = the environment (bus receiver, serializer, command source),
// slave  = the buffer itself.
interface audio_out_fifo_if #(
   parameter int DEPTH = audio_pkg::DEF_DEPTH
);

   localparam int FW = $clog2(DEPTH) + 1;

   // Sample words from the bus receiver
   logic                          wr_valid;
   logic [audio_pkg::SAMPLE_W-1:0] wr_data;

   // Playback commands
   logic                          cmd_start;
   logic                          cmd_end;
   logic                          cmd_22k;

   // Serializer request ticks and host burst request
   logic                          req_tick;
   logic                          req_mode;
   logic                          host_req;

   // Head-of-buffer handshake towards the serializer
   logic                          out_valid;
   logic [audio_pkg::SAMPLE_W-1:0] out_data;
   logic                          out_ready;

   // Status
   logic                          play_on;
   logic                          rate_22k;
   logic                          busy;
   logic                          done;
   logic [FW-1:0]                 fill;
   logic [7:0]                    underrun_cnt;
   logic                          overflow;

   modport master (
      output wr_valid, wr_data, cmd_start, cmd_end, cmd_22k,
             req_tick, req_mode, out_ready,
      input  host_req, out_valid, out_data, play_on, rate_22k,
             busy, done, fill, underrun_cnt, overflow
   );

   modport slave (
      input  wr_valid, wr_data, cmd_start, cmd_end, cmd_22k,
             req_tick, req_mode, out_ready,
      output host_req, out_valid, out_data, play_on, rate_22k,
             busy, done, fill, underrun_cnt, overflow
   );

endinterface : audio_out_fifo_if

// File: rtl/audio_out_fifo_sync_fifo.sv
// Single-clock word FIFO with registered head word, valid and fill.
// A write into a full FIFO is still accepted when a read happens in the
// same cycle; otherwise it is reported as dropped.
module sync_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = SAMPLE_W
)(
   input  logic              in_clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd,
   output logic              o_wr_acc,
   output logic              o_wr_drop,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [$clog2(DEPTH):0] o_fill
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [FW-1:0]     r_fill;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   logic              w_rd;
   logic              w_full;
   logic              w_wr_acc;
   logic [FW-1:0]     w_rem;
   logic [FW-1:0]     w_fill_nxt;
   logic [AW-1:0]     w_rd_ptr_nxt;
   logic [DATA_W-1:0] w_head_nxt;

   assign w_rd         = i_rd && r_valid;
   assign w_full       = (r_fill == FW'(DEPTH));
   assign w_wr_acc     = i_wr && (!w_full || w_rd);
   assign w_rem        = r_fill - FW'(w_rd);
   assign w_fill_nxt   = w_rem + FW'(w_wr_acc);
   assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);

   // Next head word: when nothing older survives the read, the head is the
   // word being written this cycle (or 0 if none); otherwise it comes from
   // storage at the advanced read pointer.
   always_comb begin
      w_head_nxt = '0;
      if (w_rem == '0) begin
         if (w_wr_acc) w_head_nxt = i_wr_data;
      end else begin
         w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
   end

   // Sample storage; contents need no reset because fill qualifies them
   always_ff @(posedge in_clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers, fill and registered head presentation
   always_ff @(posedge in_clk) begin
      if (!rst_n || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr <= w_rd_ptr_nxt;
         r_fill   <= w_fill_nxt;
         r_valid  <= (w_fill_nxt != '0);
         r_data   <= w_head_nxt;
      end
   end

   assign o_wr_acc  = w_wr_acc;
   assign o_wr_drop = i_wr && !w_wr_acc;
   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_fill    = r_fill;

endmodule : sync_fifo

// File: rtl/audio_out_fifo.sv
// Sound-out sample buffer ahead of the I2S serializer. Buffers bus sample
// words, converts serializer request ticks into flow-controlled host burst
// requests, sequences start/end/drain of playback and keeps status.
module audio_out_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int BURST = DEF_BURST
)(
   input  logic            in_clk,
   input  logic            rst_n,
   audio_out_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int PW = AW + 2;
   localparam logic [PW-1:0]        DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0]        BURST_U = PW'(BURST);
   localparam logic signed [PW-1:0] BURST_S = $signed(BURST_U);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t             r_state;
   logic [PW-1:0]      r_pending;
   logic               r_host_req;
   logic               r_play_on;
   logic               r_rate_22k;
   logic               r_busy;
   logic               r_done;
   logic               r_overflow;
   logic [7:0]         r_underrun_cnt;

   logic               w_wr;
   logic               w_clr;
   logic               w_wr_acc;
   logic               w_wr_drop;
   logic               w_valid;
   logic [SAMPLE_W-1:0] w_data;
   logic [FW-1:0]      w_fill;
   logic signed [PW-1:0] w_free;
   logic               w_req_fire;
   logic [PW-1:0]      w_pend_sum;
   logic [PW-1:0]      w_pend_nxt;
   logic               w_start;
   logic               w_drained;
   logic               w_underrun;

   // Writes only land while playing or draining; IDLE keeps the FIFO flushed
   assign w_wr  = bus.wr_valid && (r_state != ST_IDLE);
   assign w_clr = (r_state == ST_IDLE);

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (SAMPLE_W)
   ) u_fifo (
      .in_clk    (in_clk),
      .rst_n     (rst_n),
      .i_clr     (w_clr),
      .i_wr      (w_wr),
      .i_wr_data (bus.wr_data),
      .i_rd      (bus.out_ready),
      .o_wr_acc  (w_wr_acc),
      .o_wr_drop (w_wr_drop),
      .o_valid   (w_valid),
      .o_data    (w_data),
      .o_fill    (w_fill)
   );

   // Room not yet claimed by stored or promised words. Unsolicited words
   // can push this negative, so it is compared as a signed quantity.
   assign w_free     = $signed(DEPTH_P - PW'(w_fill) - r_pending);
   assign w_req_fire = bus.req_tick && bus.req_mode && (r_state == ST_RUN) &&
                       (w_free >= BURST_S);

   // Promised-word count: a new burst is booked at the decision edge so the
   // very next tick already sees it; each accepted word retires one.
   assign w_pend_sum = r_pending + (w_req_fire ? BURST_U : '0);
   assign w_pend_nxt = (w_wr_acc && (w_pend_sum != '0)) ? w_pend_sum - PW'(1)
                                                         : w_pend_sum;

   // A simultaneous end command overrides a start
   assign w_start    = bus.cmd_start && !bus.cmd_end;
   assign w_drained  = (w_fill == '0) && (r_pending == '0) && !w_wr_acc;
   assign w_underrun = bus.req_tick && (r_state == ST_RUN) && (w_fill == '0);

   // Playback FSM with pending tracking, host requests and status registers
   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_pending      <= '0;
         r_host_req     <= 1'b0;
         r_play_on      <= 1'b0;
         r_rate_22k     <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_overflow     <= 1'b0;
         r_underrun_cnt <= '0;
      end else begin
         r_host_req <= w_req_fire;
         r_done     <= 1'b0;
         r_pending  <= (r_state == ST_IDLE) ? '0 : w_pend_nxt;

         if (bus.cmd_start || bus.cmd_end) r_rate_22k <= bus.cmd_22k;
         if (w_wr_drop)                    r_overflow <= 1'b1;
         if (w_underrun)                   r_underrun_cnt <= sat_inc8(r_underrun_cnt);

         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state        <= ST_RUN;
                  r_play_on      <= 1'b1;
                  r_busy         <= 1'b1;
                  r_underrun_cnt <= '0;
                  r_overflow     <= 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.cmd_end) begin
                  r_state   <= ST_DRAIN;
                  r_play_on <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (w_start) begin
                  r_state   <= ST_RUN;
                  r_play_on <= 1'b1;
               end else if (w_drained) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_play_on <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.host_req     = r_host_req;
   assign bus.out_valid    = w_valid;
   assign bus.out_data     = w_data;
   assign bus.play_on      = r_play_on;
   assign bus.rate_22k     = r_rate_22k;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.fill         = w_fill;
   assign bus.underrun_cnt = r_underrun_cnt;
   assign bus.overflow     = r_overflow;

endmodule : audio_out_fifo

// File: tb/tb_audio_out_fifo.sv
// Bench for audio_out_fifo: queue-based reference model compared on every
// falling edge, plus directed scenarios with hand-computed literal values.
module tb_audio_out_fifo;

   localparam int DEPTH = 16;
   localparam int BURST = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   audio_out_fifo_if #(.DEPTH(DEPTH)) bus ();

   audio_out_fifo #(
      .DEPTH (DEPTH),
      .BURST (BURST)
   ) dut (
      .in_clk (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   int          m_st   = M_IDLE;
   logic [31:0] m_q[$];
   int          m_pend = 0;
   int          m_urun = 0;
   bit          m_ovf  = 1'b0;
   bit          m_rate = 1'b0;
   bit          m_hreq = 1'b0;
   bit          m_done = 1'b0;

   always @(posedge clk) begin : model
      int sz;
      bit rd, wr, acc, fire, start;
      if (!rst_n) begin
         m_st = M_IDLE; m_q.delete(); m_pend = 0; m_urun = 0;
         m_ovf = 1'b0; m_rate = 1'b0; m_hreq = 1'b0; m_done = 1'b0;
      end else begin
         sz    = m_q.size();
         rd    = (sz != 0) && bus.out_ready;
         wr    = bus.wr_valid && (m_st != M_IDLE);
         acc   = wr && ((sz < DEPTH) || rd);
         fire  = bus.req_tick && bus.req_mode && (m_st == M_RUN) &&
                 ((DEPTH - sz - m_pend) >= BURST);
         start = bus.cmd_start && !bus.cmd_end;
         if (bus.req_tick && (m_st == M_RUN) && (sz == 0) && (m_urun < 255)) m_urun++;
         if (wr && !acc) m_ovf = 1'b1;
         if (bus.cmd_start || bus.cmd_end) m_rate = bus.cmd_22k;
         m_hreq = fire;
         m_done = 1'b0;
         case (m_st)
            M_IDLE: if (start) begin m_st = M_RUN; m_urun = 0; m_ovf = 1'b0; end
            M_RUN:  if (bus.cmd_end) m_st = M_DRAIN;
            default: begin
               if (start) m_st = M_RUN;
               else if ((sz == 0) && (m_pend == 0) && !acc) begin
                  m_st = M_IDLE; m_done = 1'b1;
               end
            end
         endcase
         if (rd)  void'(m_q.pop_front());
         if (acc) m_q.push_back(bus.wr_data);
         m_pend = m_pend + (fire ? BURST : 0) - (acc ? 1 : 0);
         if (m_pend < 0) m_pend = 0;
         if (m_st == M_IDLE) begin m_q.delete(); m_pend = 0; end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_host_req",  32'(bus.host_req),     32'(m_hreq));
         check("m_out_valid", 32'(bus.out_valid),    32'(m_q.size() != 0));
         check("m_out_data",  bus.out_data,          (m_q.size() != 0) ? m_q[0] : 32'h0);
         check("m_fill",      32'(bus.fill),         32'(m_q.size()));
         check("m_play_on",   32'(bus.play_on),      32'(m_st == M_RUN));
         check("m_busy",      32'(bus.busy),         32'(m_st != M_IDLE));
         check("m_done",      32'(bus.done),         32'(m_done));
         check("m_rate_22k",  32'(bus.rate_22k),     32'(m_rate));
         check("m_underrun",  32'(bus.underrun_cnt), 32'(m_urun));
         check("m_overflow",  32'(bus.overflow),     32'(m_ovf));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_word(input logic [31:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      cyc();
      bus.wr_valid = 1'b0;
   endtask

   task automatic tick(input bit mode);
      bus.req_tick = 1'b1;
      bus.req_mode = mode;
      cyc();
      bus.req_tick = 1'b0;
      bus.req_mode = 1'b0;
   endtask

   task automatic cmd(input bit s, input bit e, input bit r22);
      bus.cmd_start = s;
      bus.cmd_end   = e;
      bus.cmd_22k   = r22;
      cyc();
      bus.cmd_start = 1'b0;
      bus.cmd_end   = 1'b0;
      bus.cmd_22k   = 1'b0;
   endtask

   initial begin
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.cmd_start = 1'b0;
      bus.cmd_end   = 1'b0;
      bus.cmd_22k   = 1'b0;
      bus.req_tick  = 1'b0;
      bus.req_mode  = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      cyc();
      cyc();
      chk_en = 1'b1;
      check("rst_fill",      32'(bus.fill),      32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  bus.out_data,       32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_host_req",  32'(bus.host_req),  32'd0);
      rst_n = 1'b1;
      cyc();

      // Start, request one burst, receive and play out four words
      cmd(1'b1, 1'b0, 1'b0);
      check("start_play_on", 32'(bus.play_on), 32'd1);
      tick(1'b1);
      check("req_host_req", 32'(bus.host_req), 32'd1);
      wr_word(32'h0001_0002);
      check("first_valid", 32'(bus.out_valid), 32'd1);
      check("first_data",  bus.out_data,       32'h0001_0002);
      for (int i = 1; i < 4; i++) wr_word({16'(i + 1), 16'(i + 2)});
      check("burst_fill", 32'(bus.fill), 32'd4);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rd_order", bus.out_data, {16'(i + 1), 16'(i + 2)});
         cyc();
      end
      bus.out_ready = 1'b0;
      check("empty_valid", 32'(bus.out_valid), 32'd0);
      check("empty_data",  bus.out_data,       32'd0);

      // Request threshold: 13 stored leaves room for 3 only
      for (int i = 0; i < 13; i++) wr_word(32'hA000_0000 + 32'(i));
      check("fill13", 32'(bus.fill), 32'd13);
      tick(1'b1);
      check("fill13_no_req", 32'(bus.host_req), 32'd0);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      check("fill12", 32'(bus.fill), 32'd12);
      tick(1'b1);
      check("fill12_req", 32'(bus.host_req), 32'd1);

      // Full buffer: write with read is accepted, write alone is dropped
      for (int i = 0; i < 4; i++) wr_word(32'hB000_0000 + 32'(i));
      check("fill16", 32'(bus.fill), 32'd16);
      bus.out_ready = 1'b1;
      wr_word(32'hC000_0000);
      bus.out_ready = 1'b0;
      check("full_rw_fill", 32'(bus.fill),     32'd16);
      check("full_rw_ovf",  32'(bus.overflow), 32'd0);
      check("full_rw_head", bus.out_data,      32'hA000_0002);
      wr_word(32'hD000_0000);
      check("drop_fill", 32'(bus.fill),     32'd16);
      check("drop_ovf",  32'(bus.overflow), 32'd1);

      // Underrun saturation, then a fresh start clears the status
      bus.out_ready = 1'b1;
      repeat (16) cyc();
      bus.out_ready = 1'b0;
      check("drained_fill", 32'(bus.fill), 32'd0);
      for (int i = 0; i < 300; i++) tick(1'b0);
      check("urun_sat", 32'(bus.underrun_cnt), 32'd255);
      cmd(1'b0, 1'b1, 1'b0);
      check("end_busy", 32'(bus.busy), 32'd1);
      cyc();
      check("empty_drain_done", 32'(bus.done), 32'd1);
      cmd(1'b1, 1'b0, 1'b1);
      check("restart_urun", 32'(bus.underrun_cnt), 32'd0);
      check("restart_ovf",  32'(bus.overflow),     32'd0);
      check("restart_rate", 32'(bus.rate_22k),     32'd1);

      // Drain with a burst still in flight
      for (int i = 0; i < 3; i++) wr_word(32'hE000_0000 + 32'(i));
      tick(1'b1);
      check("drain_pre_req", 32'(bus.host_req), 32'd1);
      cmd(1'b0, 1'b1, 1'b1);
      check("drain_play_on", 32'(bus.play_on), 32'd0);
      tick(1'b1);
      check("drain_no_req", 32'(bus.host_req), 32'd0);
      for (int i = 0; i < 4; i++) wr_word(32'hF000_0000 + 32'(i));
      check("drain_fill7", 32'(bus.fill), 32'd7);
      bus.out_ready = 1'b1;
      repeat (7) cyc();
      bus.out_ready = 1'b0;
      check("drain_not_done", 32'(bus.done), 32'd0);
      cyc();
      check("drain_done",      32'(bus.done), 32'd1);
      check("drain_done_busy", 32'(bus.busy), 32'd0);
      cyc();
      check("done_pulse_end", 32'(bus.done), 32'd0);

      // Start+end together lands in DRAIN; reset clears everything there
      cmd(1'b1, 1'b0, 1'b1);
      tick(1'b0);
      check("urun_one", 32'(bus.underrun_cnt), 32'd1);
      cmd(1'b1, 1'b1, 1'b1);
      check("both_cmd_play", 32'(bus.play_on), 32'd0);
      check("both_cmd_busy", 32'(bus.busy),    32'd1);
      wr_word(32'h0000_0099);
      check("drain_hold_fill", 32'(bus.fill), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check("mid_rst_fill",  32'(bus.fill),         32'd0);
      check("mid_rst_busy",  32'(bus.busy),         32'd0);
      check("mid_rst_rate",  32'(bus.rate_22k),     32'd0);
      check("mid_rst_urun",  32'(bus.underrun_cnt), 32'd0);
      check("mid_rst_valid", 32'(bus.out_valid),    32'd0);
      check("mid_rst_data",  bus.out_data,          32'd0);
      wr_word(32'h0000_0077);
      wr_word(32'h0000_0078);
      check("post_rst_ignored", 32'(bus.fill), 32'd0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_audio_out_fifo
